// File: rtl/uart_pkg.sv
// Shared UART definitions: 3-bit FSM encodings common to the transmitter and
// receiver, the default bit-period divider and parity-sense constants.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_START   = 3'd1;
  localparam state_t S_DATA    = 3'd2;
  localparam state_t S_PARITY  = 3'd3;
  localparam state_t S_STOP    = 3'd4;
  localparam state_t S_CLEANUP = 3'd5;

  // 100 MHz system clock at 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 868;

  localparam logic PARITY_SENSE_EVEN = 1'b0;
  localparam logic PARITY_SENSE_ODD  = 1'b1;

  // Counter value at the middle of the start bit.
  function automatic int mid_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pin inputs.
// RST_VAL sets the value both flops take while rst_n is low.
module uart_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, 1 start, 1 stop, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN to insert a parity bit and add o_Parity_Err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 12
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = PARITY_SENSE_EVEN
`endif
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_Parity_Err,
`endif
  output logic       o_Frame_Err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_count(CLKS_PER_BIT));

  logic             rx_s;
  logic             rx_prev;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;

  uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .d     (i_Rx_Serial),
    .q     (rx_s)
  );

  // Previous synced value keeps edge history across CLEANUP for back-to-back frames.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_prev <= 1'b1;
    else          rx_prev <= rx_s;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ((^shift) ^ par_bit) != PARITY_ODD;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Byte   <= 8'h00;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_Parity_Err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (rx_prev && !rx_s) begin
            state       <= S_START;
            o_Rx_Active <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
            end else begin
              state       <= S_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == 3'd7) begin
              idx <= '0;
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_CLEANUP;
`ifdef UART_RX_PARITY_EN
            // A parity failure withholds the byte; both error strobes may fire together.
            if (rx_s && !par_bad) begin
              o_Rx_Byte <= shift;
              o_Rx_DV   <= 1'b1;
            end
            if (!rx_s)  o_Frame_Err  <= 1'b1;
            if (par_bad) o_Parity_Err <= 1'b1;
`else
            if (rx_s) begin
              o_Rx_Byte <= shift;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Frame_Err <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_CLEANUP: begin
          o_Rx_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
          o_Parity_Err <= 1'b0;
`endif
          o_Rx_Active <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          idx         <= '0;
          o_Rx_DV     <= 1'b0;
          o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
          o_Parity_Err <= 1'b0;
`endif
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit: a table of framed bytes
// plus hand-written glitch, break, back-to-back, reset and parity sequences.
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_NOM = 2 + (CPB - 1) / 2 + 10 * CPB + 1;
`else
  localparam int LAT_NOM = 2 + (CPB - 1) / 2 + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  logic       par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(12)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_Serial (rx),
    .o_Rx_DV     (dv),
    .o_Rx_Byte   (rbyte),
    .o_Rx_Active (active),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err(perr),
`endif
    .o_Frame_Err (ferr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Output monitor, sampled on the falling edge.
  int         cyc = 0;
  int         dv_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  int         width_err = 0, both_err = 0, act_err = 0;
  int         dv_cyc = 0;
  logic       dv_prev = 1'b0, fe_prev = 1'b0, act_seen = 1'b0;
  logic [7:0] dv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dv_prev <= dv;
    fe_prev <= ferr;
    if (active) act_seen <= 1'b1;
    if (dv) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc <= cyc;
      dv_q.push_back(rbyte);
      if (dv_prev) width_err <= width_err + 1;
    end
    if (ferr) begin
      fe_cnt <= fe_cnt + 1;
      if (fe_prev) width_err <= width_err + 1;
    end
    if (dv && ferr) both_err <= both_err + 1;
    if (dv_prev && active) act_err <= act_err + 1;
`ifdef UART_RX_PARITY_EN
    if (perr) pe_cnt <= pe_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dv0, fe0, pe0, c0, n0;
    logic [7:0] b0, b1;

    vecs[0] = '{8'h37, 1'b1, 1, 0, 8'h37};
    vecs[1] = '{8'hA5, 1'b0, 0, 1, 8'h37};
    vecs[2] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
    vecs[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[4] = '{8'h80, 1'b0, 0, 1, 8'h01};
    vecs[5] = '{8'h6E, 1'b1, 1, 0, 8'h6E};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dv", 32'(dv), 32'd0);
    check("reset_byte", 32'(rbyte), 32'h00);
    check("reset_active", 32'(active), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    rst_n = 1'b1;
    idle(4);
    check("idle_active", 32'(active), 32'd0);

    for (int v = 0; v < 6; v++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      c0  = cyc;
      send_frame(vecs[v].data, vecs[v].stop_bit);
      idle(2 * CPB);
      check($sformatf("vec%0d_dv_count", v), 32'(dv_cnt - dv0), 32'(vecs[v].exp_dv));
      check($sformatf("vec%0d_fe_count", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_byte", v), 32'(rbyte), 32'(vecs[v].exp_byte));
      if (v == 0)
        check("vec0_latency_in_window",
              32'((dv_cyc - c0 >= LAT_NOM - 2) && (dv_cyc - c0 <= LAT_NOM + 2)), 32'd1);
    end

    // Two-cycle glitch: aborted at the mid-start check.
    dv0 = dv_cnt; fe0 = fe_cnt;
    act_seen = 1'b0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CPB);
    check("glitch_active_seen", 32'(act_seen), 32'd1);
    check("glitch_active_now", 32'(active), 32'd0);
    check("glitch_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_fe_count", 32'(fe_cnt - fe0), 32'd0);

    // Framing error followed by a held-low break line.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    check("break_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("break_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("break_byte_held", 32'(rbyte), 32'h6E);
    check("break_active", 32'(active), 32'd0);
    idle(2 * CPB);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt;
    n0  = dv_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * CPB);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    b0 = (dv_q.size() > n0)     ? dv_q[n0]     : 8'hxx;
    b1 = (dv_q.size() > n0 + 1) ? dv_q[n0 + 1] : 8'hxx;
    check("b2b_first_byte", 32'(b0), 32'h00);
    check("b2b_second_byte", 32'(b1), 32'hFF);

    // Reset asserted during data bit 4.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe_active", 32'(active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_dv", 32'(dv), 32'd0);
    check("rst_mid_byte", 32'(rbyte), 32'h00);
    check("rst_mid_active", 32'(active), 32'd0);
    check("rst_mid_ferr", 32'(ferr), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    check("post_rst_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("post_rst_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("post_rst_byte", 32'(rbyte), 32'h5A);

`ifdef UART_RX_PARITY_EN
    dv0 = dv_cnt; pe0 = pe_cnt;
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1);
    idle(2 * CPB);
    check("par_good_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("par_good_pe_count", 32'(pe_cnt - pe0), 32'd0);
    check("par_good_byte", 32'(rbyte), 32'h03);
    dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    par_flip = 1'b1;
    send_frame(8'h7C, 1'b1);
    idle(2 * CPB);
    check("par_bad_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("par_bad_pe_count", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("par_bad_byte_held", 32'(rbyte), 32'h03);
    par_flip = 1'b0;
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", 32'(pe0), 32'd0);
`endif

    check("strobe_width_errors", 32'(width_err), 32'd0);
    check("dv_fe_overlap", 32'(both_err), 32'd0);
    check("active_after_strobe", 32'(act_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
